nibble_fifo_stage: RTL

NIBBLE_FIFO_STAGE -- requirements
Module: nibble_fifo_stage

---
 rtl/nibble_fifo_stage_pkg.sv | 26 ++
 rtl/nibble_fifo_stage_edge_detect_rise.sv | 22 ++
 rtl/nibble_fifo_stage.sv | 101 ++++++++++
 3 files changed

// File: rtl/nibble_fifo_stage_pkg.sv
// Shared constants for the nibble FIFO stage: size defaults, io bit map,
// and the pointer-width helper.
package nibble_fifo_stage_pkg;

  localparam int unsigned DEFAULT_DEPTH = 4;
  localparam int unsigned DEFAULT_WIDTH = 4;

  // io_in bit map
  localparam int unsigned IO_CLK     = 0;
  localparam int unsigned IO_RST     = 1;
  localparam int unsigned IO_PUSH    = 2;
  localparam int unsigned IO_POP     = 3;
  localparam int unsigned IO_DATA_LO = 4;

  // io_out bit map (data occupies [WIDTH-1:0])
  localparam int unsigned OUT_EMPTY = 4;
  localparam int unsigned OUT_FULL  = 5;
  localparam int unsigned OUT_OVF   = 6;
  localparam int unsigned OUT_UDF   = 7;

  // Pointer width for a power-of-two depth; never below one bit.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/nibble_fifo_stage_edge_detect_rise.sv
// Rising-edge detector: one flop holding the previous level, event is
// high for the single cycle in which the level is high and was low.
module edge_detect_rise (
  input  logic clk,
  input  logic level,
  output logic ev
);

  logic level_q;

  // Previous-level register. It follows the level even through reset so a
  // level already high when reset releases does not look like a fresh rise.
  always_ff @(posedge clk) begin
    level_q <= level;
  end

  // Event decode from current level and registered history.
  always_comb begin
    ev = level & ~level_q;
  end

endmodule

// File: rtl/nibble_fifo_stage.sv
// Nibble FIFO stage: edge-triggered push/pop of 4-bit entries with
// empty/full status and sticky overflow/underflow flags, all packed on
// an 8-bit io bus (clock and reset arrive on io_in as well).
module nibble_fifo_stage
  import nibble_fifo_stage_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  localparam int unsigned PW = ptr_width(DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] wr_data;
  logic             push_ev;
  logic             pop_ev;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic [PW:0]      count_nxt;
  logic             overflow;
  logic             underflow;

  logic             do_push;
  logic             do_pop;
  logic             is_empty;
  logic             is_full;
  logic [WIDTH-1:0] head;

  assign clk     = io_in[IO_CLK];
  assign rst     = io_in[IO_RST];
  assign wr_data = io_in[IO_DATA_LO +: WIDTH];

  edge_detect_rise u_push_edge (
    .clk   (clk),
    .level (io_in[IO_PUSH]),
    .ev    (push_ev)
  );

  edge_detect_rise u_pop_edge (
    .clk   (clk),
    .level (io_in[IO_POP]),
    .ev    (pop_ev)
  );

  // Accept/drop decisions and next count. A push at full is accepted only
  // when a pop frees the head slot in the same cycle; a pop at empty is dropped.
  always_comb begin
    is_empty  = (count == '0);
    is_full   = (count == FULL_COUNT);
    do_push   = push_ev & (~is_full | pop_ev);
    do_pop    = pop_ev & ~is_empty;
    count_nxt = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + (PW+1)'(1);
      2'b01:   count_nxt = count - (PW+1)'(1);
      default: count_nxt = count;
    endcase
  end

  // Pointers, occupancy and sticky error flags; reset discards the queue.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count_nxt;
      if (push_ev & ~pop_ev & is_full) overflow  <= 1'b1;
      if (pop_ev & is_empty)           underflow <= 1'b1;
    end
  end

  // Entry storage; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (!rst && do_push) mem[wr_ptr] <= wr_data;
  end

  // Output bus decoded from registers only.
  always_comb begin
    head              = is_empty ? '0 : mem[rd_ptr];
    io_out            = '0;
    io_out[WIDTH-1:0] = head;
    io_out[OUT_EMPTY] = is_empty;
    io_out[OUT_FULL]  = is_full;
    io_out[OUT_OVF]   = overflow;
    io_out[OUT_UDF]   = underflow;
  end

endmodule
